// File: rtl/fsm_serial_tx.sv
// -----------------------------------------------------------------------------
// fsm_serial_tx
//   Byte-wide to serial-line transmitter with a one-entry holding buffer.
//   Each frame: start bit (0), d0..d7 LSB first, optional odd parity bit,
//   stop bit (1), one bit per clk cycle. A byte offered while a frame is in
//   flight is held in the buffer and sent back-to-back with no idle gap.
//
// Parameters
//   PARITY   0 = no parity bit, 1 = odd parity bit after d7
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-high reset
//   valid    in   producer offers in_byte
//   in_byte  in   byte to send, captured on valid & ready
//   ready    out  holding buffer free (registered)
//   out      out  serial line, registered, idles at 1
//   busy     out  FSM is not idle
//   done     out  high for the stop-bit cycle of every frame
// -----------------------------------------------------------------------------
module fsm_serial_tx #(
    parameter int unsigned PARITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] in_byte,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    localparam bit HasParity = (PARITY != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_buf,   w_buf_d;
    logic       r_full,  w_full_d;
    logic       r_ready, w_ready_d;
    logic [7:0] r_shift, w_shift_d;
    logic [2:0] r_cnt,   w_cnt_d;
    logic       r_par,   w_par_d;
    logic       r_out,   w_out_d;
    logic       w_accept;
    logic       w_load;

    assign w_accept = valid & r_ready;

    // Frame sequencing. r_out is registered, so every branch sets the line
    // level for the state being entered.
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_par_d   = r_par;
        w_out_d   = r_out;
        w_load    = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_out_d = 1'b1;
                if (r_full) begin
                    w_state_d = StStart;
                    w_load    = 1'b1;
                    w_out_d   = 1'b0;
                end
            end
            StStart: begin
                w_state_d = StData;
                w_out_d   = r_shift[0];
                w_shift_d = r_shift >> 1;
                w_cnt_d   = 3'd0;
            end
            StData: begin
                if (r_cnt == 3'd7) begin
                    if (HasParity) begin
                        w_state_d = StPar;
                        w_out_d   = r_par;
                    end else begin
                        w_state_d = StStop;
                        w_out_d   = 1'b1;
                    end
                end else begin
                    w_out_d   = r_shift[0];
                    w_shift_d = r_shift >> 1;
                    w_cnt_d   = r_cnt + 3'd1;
                end
            end
            StPar: begin
                w_state_d = StStop;
                w_out_d   = 1'b1;
            end
            StStop: begin
                // A buffered byte starts immediately: no idle cycle between frames.
                if (r_full) begin
                    w_state_d = StStart;
                    w_load    = 1'b1;
                    w_out_d   = 1'b0;
                end else begin
                    w_state_d = StIdle;
                    w_out_d   = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_out_d   = 1'b1;
            end
        endcase

        if (w_load) begin
            w_shift_d = r_buf;
            // Odd parity: set when the data byte has an even number of ones.
            w_par_d   = ~^r_buf;
        end
    end

    // Holding buffer. ready drops on the accept edge and only rises one edge
    // after the buffer has been unloaded, so accept and unload never overlap.
    always_comb begin
        w_buf_d  = r_buf;
        w_full_d = r_full;
        if (w_load) begin
            w_full_d = 1'b0;
        end
        if (w_accept) begin
            w_full_d = 1'b1;
            w_buf_d  = in_byte;
        end
        w_ready_d = ~r_full & ~w_accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_buf   <= 8'd0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
            r_shift <= 8'd0;
            r_cnt   <= 3'd0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_buf   <= w_buf_d;
            r_full  <= w_full_d;
            r_ready <= w_ready_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_par   <= w_par_d;
            r_out   <= w_out_d;
        end
    end

    assign ready = r_ready;
    assign out   = r_out;
    assign busy  = (r_state != StIdle);
    assign done  = (r_state == StStop);

endmodule

// File: tb/tb_fsm_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fsm_serial_tx
//   Two transmitters (PARITY=0 and PARITY=1) on a shared clock and reset.
//   Drivers push the expected frame (byte + first frame edge) into a per-DUT
//   queue on each accepted transfer; a negedge monitor collects the line bits
//   while busy and compares a whole frame whenever done is seen.
// -----------------------------------------------------------------------------
module tb_fsm_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       vld0, vld1;
    logic [7:0] din0, din1;
    logic       rdy0, rdy1, so0, so1, bsy0, bsy1, dn0, dn1;
    logic [1:0] rdy, so, bsy, dn;

    assign rdy = {rdy1, rdy0};
    assign so  = {so1, so0};
    assign bsy = {bsy1, bsy0};
    assign dn  = {dn1, dn0};

    fsm_serial_tx #(.PARITY(0)) u_dut0 (
        .clk     (clk),
        .reset   (reset),
        .valid   (vld0),
        .in_byte (din0),
        .ready   (rdy0),
        .out     (so0),
        .busy    (bsy0),
        .done    (dn0)
    );

    fsm_serial_tx #(.PARITY(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .valid   (vld1),
        .in_byte (din1),
        .ready   (rdy1),
        .out     (so1),
        .busy    (bsy1),
        .done    (dn1)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   prev_end [2];
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic int flen(int i);
        return (i == 1) ? 11 : 10;
    endfunction

    // Reference frame: start 0, data LSB first, odd parity (DUT1), stop 1.
    function automatic int ref_frame(int i, logic [7:0] b);
        int ones = 0;
        int f    = 0;
        for (int j = 0; j < 8; j++) begin
            ones += (b >> j) & 1;
            f    |= ((b >> j) & 1) << (j + 1);
        end
        if (i == 1) begin
            f |= ((ones % 2 == 0) ? 1 : 0) << 9;
            f |= 1 << 10;
        end else begin
            f |= 1 << 9;
        end
        return f;
    endfunction

    // Called at a negedge when the next posedge accepts b.
    function automatic int push_exp(int i, logic [7:0] b);
        exp_t e;
        int   k = edge_cnt + 1;
        int   s = (k + 1 > prev_end[i]) ? k + 1 : prev_end[i];
        prev_end[i] = s + flen(i);
        e.b     = b;
        e.start = s;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        return s;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [11:0] got [2];
    int          n [2];
    int          st [2];
    int          last_done [2];
    int          prev_done [2];

    function automatic void finish_frame(int i);
        exp_t e;
        int   act = 0;
        int   have;
        have = (i == 0) ? q0.size() : q1.size();
        if (have == 0) begin
            check($sformatf("unexpected_frame_dut%0d", i), 1, 0);
        end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            for (int j = 0; j < n[i] && j < 12; j++) act |= int'(got[i][j]) << j;
            check($sformatf("frame_len_dut%0d_b%02h", i, e.b), n[i], flen(i));
            check($sformatf("frame_bits_dut%0d_b%02h", i, e.b), act, ref_frame(i, e.b));
            check($sformatf("frame_start_dut%0d_b%02h", i, e.b), st[i], e.start);
        end
        prev_done[i] = last_done[i];
        last_done[i] = edge_cnt;
        n[i]         = 0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                n[i] = 0;
            end else if (bsy[i]) begin
                if (n[i] == 0) st[i] = edge_cnt;
                if (n[i] < 12) got[i][n[i]] = so[i];
                n[i]++;
                if (dn[i]) begin
                    finish_frame(i);
                end else if (n[i] >= 12) begin
                    check($sformatf("frame_overrun_dut%0d", i), n[i], flen(i));
                    n[i] = 0;
                end
            end else begin
                check($sformatf("idle_out_done_dut%0d", i), {so[i], dn[i]}, 2);
                if (n[i] != 0) begin
                    check($sformatf("frame_cut_dut%0d", i), n[i], 0);
                    n[i] = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic drive(input int i, input logic v, input logic [7:0] d);
        if (i == 0) begin
            vld0 = v;
            din0 = d;
        end else begin
            vld1 = v;
            din1 = d;
        end
    endtask

    // Called right after a negedge; holds valid and in_byte until accepted.
    task automatic send(input int i, input logic [7:0] b, output int s);
        int guard = 0;
        s = -1;
        drive(i, 1'b1, b);
        while (!rdy[i] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[i]) begin
            check($sformatf("ready_timeout_dut%0d", i), 0, 1);
        end else begin
            s = push_exp(i, b);
        end
        @(negedge clk);
        // Scramble in_byte once the transfer is over; it must not matter.
        drive(i, 1'b0, 8'($urandom));
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bsy != 2'b00) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", q0.size() + q1.size() + int'(bsy != 2'b00), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ready_dut%0d", tag, i), rdy[i], 1);
            check($sformatf("%s_out_dut%0d", tag, i), so[i], 1);
            check($sformatf("%s_busy_dut%0d", tag, i), bsy[i], 0);
            check($sformatf("%s_done_dut%0d", tag, i), dn[i], 0);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int s;
        reset = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        prev_end[0] = 0;
        prev_end[1] = 0;
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; st[i] = 0; last_done[i] = 0; prev_done[i] = 0; got[i] = '0;
        end
        #1 reset = 1'b1;

        // Reset held for two cycles, then idle with valid low.
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("after_reset");

        // Single byte, first start bit one cycle after the transfer edge.
        send(0, 8'hA5, s);
        @(negedge clk);
        check("latency_start_out", so0, 0);
        check("latency_start_busy", bsy0, 1);
        drain();

        // Back-to-back: 0xFF accepted mid-frame, no idle gap.
        send(0, 8'h00, s);
        send(0, 8'hFF, s);
        drain();
        check("b2b_done_spacing", last_done[0] - prev_done[0], 10);

        // Odd parity frames.
        send(1, 8'h01, s);
        drain();
        send(1, 8'h00, s);
        drain();

        // Backpressure: 0x3C held while ready is low, sent exactly once.
        send(0, 8'h11, s);
        send(0, 8'h3C, s);
        drain();

        // Reset during d3 of 0xA5 with 0x77 waiting in the buffer.
        send(0, 8'hA5, s);
        begin
            int s2;
            send(0, 8'h77, s2);
        end
        while (edge_cnt < s + 4) @(negedge clk);
        check("pre_reset_d3", so0, 0);
        #2 reset = 1'b1;
        #1;
        check("midreset_out", so0, 1);
        check("midreset_busy", bsy0, 0);
        check("midreset_ready", rdy0, 1);
        check("midreset_done", dn0, 0);
        q0.delete();
        q1.delete();
        prev_end[0] = 0;
        prev_end[1] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(0, 8'h5A, s);
        drain();

        // Randomised traffic on both transmitters at once.
        fork
            begin
                int sr;
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                    send(0, 8'($urandom), sr);
                end
            end
            begin
                int sr;
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                    send(1, 8'($urandom), sr);
                end
            end
        join
        drain();
        repeat (3) @(negedge clk);
        check("final_ready_dut0", rdy0, 1);
        check("final_ready_dut1", rdy1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
